tmu2_burst_collect: RTL and testbench

- Sits downstream of the TMU2 bilinear blend stage.
- Receives blended 16-bit RGB565 pixels with destination halfword addresses on a stb/ack pipe handshake.
- Coalesces pixels that fall in the same 32-byte (16-pixel) FML burst into one burst record: address, per-pixel select mask, 256-bit data.
- Hands each burst record over the same stb/ack handshake to the FML write master.

---
 rtl/tmu2_burst_collect_if.sv | 27 ++
 rtl/tmu2_burst_collect.sv | 79 +++++++
 tb/tb_tmu2_burst_collect.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/tmu2_burst_collect_if.sv
// Pixel-in and burst-out handshake bundle for the TMU2 burst collector.
// The slave modport is the collector's view; the master modport drives it.
interface tmu2_burst_collect_if #(
  parameter int fml_depth = 26
);
  logic                 flush;
  logic                 busy;
  logic                 pipe_stb_i;
  logic                 pipe_ack_o;
  logic [fml_depth-2:0] dadr;
  logic [15:0]          color;
  logic                 pipe_stb_o;
  logic                 pipe_ack_i;
  logic [fml_depth-6:0] burst_addr;
  logic [15:0]          burst_sel;
  logic [255:0]         burst_do;

  modport slave (
    input  flush, pipe_stb_i, dadr, color, pipe_ack_i,
    output busy, pipe_ack_o, pipe_stb_o, burst_addr, burst_sel, burst_do
  );

  modport master (
    output flush, pipe_stb_i, dadr, color, pipe_ack_i,
    input  busy, pipe_ack_o, pipe_stb_o, burst_addr, burst_sel, burst_do
  );
endinterface

// File: rtl/tmu2_burst_collect.sv
// Coalesces RGB565 pixels sharing a 32-byte FML burst into one record
// (address, select mask, 256-bit big-endian data) for the FML write master.
module tmu2_burst_collect #(
  parameter int fml_depth = 26
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  tmu2_burst_collect_if.slave  bus
);
  localparam int TW = fml_depth - 5;

  logic [TW-1:0]  tag;
  logic [15:0]    sel;
  logic [255:0]   data;

  logic [TW-1:0]  in_tag;
  logic [3:0]     idx;
  logic [15:0]    idx_bit;
  logic           empty;
  logic           full;
  logic           match;
  logic           out_free;
  logic           xfer;
  logic           accept;

  assign in_tag   = bus.dadr[fml_depth-2:4];
  assign idx      = bus.dadr[3:0];
  assign idx_bit  = 16'h8000 >> idx;
  assign empty    = (sel == 16'h0000);
  assign full     = (sel == 16'hFFFF);
  assign match    = ~empty & (in_tag == tag);
  assign out_free = ~bus.pipe_stb_o | bus.pipe_ack_i;
  assign xfer     = out_free & ~empty &
                    ((bus.pipe_stb_i & ~match) | full | (bus.flush & ~bus.pipe_stb_i));

  assign bus.pipe_ack_o = empty | match | xfer;
  assign accept         = bus.pipe_stb_i & bus.pipe_ack_o;
  assign bus.busy       = ~empty | bus.pipe_stb_o;

  // A pixel accepted together with a transfer always starts a fresh buffer,
  // even if its tag matches the (full) buffer being emitted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tag <= '0;
      sel <= '0;
    end else if (xfer) begin
      if (bus.pipe_stb_i) begin
        tag <= in_tag;
        sel <= idx_bit;
      end else begin
        sel <= '0;
      end
    end else if (accept) begin
      if (empty) tag <= in_tag;
      sel <= sel | idx_bit;
    end
  end

  // Lane contents need no reset; sel alone decides which lanes are valid.
  always_ff @(posedge sys_clk) begin
    if (accept) data[{~idx, 4'b0000} +: 16] <= bus.color;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.pipe_stb_o <= 1'b0;
      bus.burst_addr <= '0;
      bus.burst_sel  <= '0;
      bus.burst_do   <= '0;
    end else if (xfer) begin
      bus.pipe_stb_o <= 1'b1;
      bus.burst_addr <= tag;
      bus.burst_sel  <= sel;
      bus.burst_do   <= data;
    end else if (bus.pipe_ack_i) begin
      bus.pipe_stb_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tmu2_burst_collect.sv
// Directed bench for tmu2_burst_collect: full burst, tag change, overwrite,
// backpressure, flush versus input, and asynchronous reset mid-operation.
module tb_tmu2_burst_collect;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [255:0] exp_do;

  tmu2_burst_collect_if #(.fml_depth(26)) bus ();

  tmu2_burst_collect #(.fml_depth(26)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic px(input logic [24:0] a, input logic [15:0] c);
    bus.pipe_stb_i = 1'b1;
    bus.dadr       = a;
    bus.color      = c;
    #1;
  endtask

  task automatic idle();
    bus.pipe_stb_i = 1'b0;
    #1;
  endtask

  initial begin
    bus.flush      = 1'b0;
    bus.pipe_stb_i = 1'b0;
    bus.dadr       = '0;
    bus.color      = '0;
    bus.pipe_ack_i = 1'b1;
    #12;
    chk("rst_ack_o", bus.pipe_ack_o, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stb_o", bus.pipe_stb_o, 0);
    chk("rst_sel", bus.burst_sel, 0);
    #5 sys_rst_n = 1'b1;
    cyc();

    // Full burst: 16 consecutive pixels of burst 0x10
    exp_do = '0;
    for (int i = 0; i < 16; i++) begin
      px(25'h100 + 25'(i), 16'(i + 1));
      exp_do[255 - 16*i -: 16] = 16'(i + 1);
      chk($sformatf("full_ack_%0d", i), bus.pipe_ack_o, 1);
      chk($sformatf("full_nostb_%0d", i), bus.pipe_stb_o, 0);
      cyc();
    end
    idle();
    chk("full_stb_wait", bus.pipe_stb_o, 0);
    chk("full_busy", bus.busy, 1);
    cyc();
    chk("full_stb", bus.pipe_stb_o, 1);
    chk("full_addr", bus.burst_addr, 21'h10);
    chk("full_sel", bus.burst_sel, 16'hFFFF);
    chk("full_first", bus.burst_do[255:240], 16'h0001);
    chk("full_last", bus.burst_do[15:0], 16'h0010);
    chk("full_do", bus.burst_do, exp_do);
    cyc();
    chk("full_done_stb", bus.pipe_stb_o, 0);
    chk("full_done_busy", bus.busy, 0);

    // Tag change, then flush with idle input
    px(25'h105, 16'h1234);
    chk("tag_ack0", bus.pipe_ack_o, 1);
    cyc();
    px(25'h205, 16'h5678);
    chk("tag_ack1", bus.pipe_ack_o, 1);
    cyc();
    idle();
    bus.flush = 1'b1;
    #1;
    chk("tag_r0_stb", bus.pipe_stb_o, 1);
    chk("tag_r0_addr", bus.burst_addr, 21'h10);
    chk("tag_r0_sel", bus.burst_sel, 16'h0400);
    chk("tag_r0_data", bus.burst_do[175:160], 16'h1234);
    cyc();
    chk("tag_r1_stb", bus.pipe_stb_o, 1);
    chk("tag_r1_addr", bus.burst_addr, 21'h20);
    chk("tag_r1_sel", bus.burst_sel, 16'h0400);
    chk("tag_r1_data", bus.burst_do[175:160], 16'h5678);
    cyc();
    chk("tag_end_stb", bus.pipe_stb_o, 0);
    chk("tag_end_busy", bus.busy, 0);
    cyc();
    chk("tag_flush_held", bus.pipe_stb_o, 0);
    bus.flush = 1'b0;

    // Overwrite of the same lane: later pixel wins
    px(25'h103, 16'hAAAA);
    cyc();
    px(25'h103, 16'h5555);
    chk("ovw_ack", bus.pipe_ack_o, 1);
    cyc();
    idle();
    bus.flush = 1'b1;
    #1;
    chk("ovw_nostb", bus.pipe_stb_o, 0);
    cyc();
    bus.flush = 1'b0;
    chk("ovw_stb", bus.pipe_stb_o, 1);
    chk("ovw_addr", bus.burst_addr, 21'h10);
    chk("ovw_sel", bus.burst_sel, 16'h1000);
    chk("ovw_data", bus.burst_do[207:192], 16'h5555);
    cyc();
    chk("ovw_end_stb", bus.pipe_stb_o, 0);
    chk("ovw_end_busy", bus.busy, 0);

    // Backpressure
    bus.pipe_ack_i = 1'b0;
    px(25'h100, 16'h0A01);
    cyc();
    px(25'h200, 16'h0A02);
    chk("bp_ack_200", bus.pipe_ack_o, 1);
    cyc();
    px(25'h300, 16'h0A03);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_stall_%0d", i), bus.pipe_ack_o, 0);
      chk($sformatf("bp_hold_stb_%0d", i), bus.pipe_stb_o, 1);
      chk($sformatf("bp_hold_addr_%0d", i), bus.burst_addr, 21'h10);
      chk($sformatf("bp_hold_sel_%0d", i), bus.burst_sel, 16'h8000);
      chk($sformatf("bp_hold_data_%0d", i), bus.burst_do[255:240], 16'h0A01);
      cyc();
    end
    bus.pipe_ack_i = 1'b1;
    #1;
    chk("bp_ack_300", bus.pipe_ack_o, 1);
    cyc();
    bus.pipe_ack_i = 1'b0;
    idle();
    chk("bp_r1_stb", bus.pipe_stb_o, 1);
    chk("bp_r1_addr", bus.burst_addr, 21'h20);
    chk("bp_r1_data", bus.burst_do[255:240], 16'h0A02);
    bus.pipe_ack_i = 1'b1;
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("bp_r2_stb", bus.pipe_stb_o, 1);
    chk("bp_r2_addr", bus.burst_addr, 21'h30);
    chk("bp_r2_sel", bus.burst_sel, 16'h8000);
    chk("bp_r2_data", bus.burst_do[255:240], 16'h0A03);
    cyc();
    chk("bp_end_busy", bus.busy, 0);

    // Flush held while same-tag pixels stream in
    bus.flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      px(25'h400 + 25'(i), 16'h0B00 + 16'(i));
      chk($sformatf("fl_ack_%0d", i), bus.pipe_ack_o, 1);
      cyc();
      chk($sformatf("fl_nostb_%0d", i), bus.pipe_stb_o, 0);
    end
    idle();
    cyc();
    chk("fl_stb", bus.pipe_stb_o, 1);
    chk("fl_addr", bus.burst_addr, 21'h40);
    chk("fl_sel", bus.burst_sel, 16'hF000);
    chk("fl_data", bus.burst_do[255:192], 64'h0B00_0B01_0B02_0B03);
    cyc();
    chk("fl_end_stb", bus.pipe_stb_o, 0);
    bus.flush = 1'b0;

    // Asynchronous reset with a pending record and a partial buffer
    bus.pipe_ack_i = 1'b0;
    px(25'h500, 16'h0001);
    cyc();
    px(25'h600, 16'h0002);
    cyc();
    idle();
    chk("rm_pre_stb", bus.pipe_stb_o, 1);
    chk("rm_pre_busy", bus.busy, 1);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rm_stb", bus.pipe_stb_o, 0);
    chk("rm_busy", bus.busy, 0);
    chk("rm_sel", bus.burst_sel, 0);
    chk("rm_ack_o", bus.pipe_ack_o, 1);
    #1 sys_rst_n = 1'b1;
    bus.pipe_ack_i = 1'b1;
    bus.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("rm_nostale_%0d", i), bus.pipe_stb_o, 0);
    end
    chk("rm_end_busy", bus.busy, 0);
    bus.flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
